// File: rtl/counter_sequencer.sv
// counter_sequencer: debounces the run/step/dir buttons, runs the run/pause
// FSM and the tick divider, and drives the counter datapath with a one-cycle
// step strobe plus a registered direction level.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_PAUSE | divider held at 0; step button issues one step
//   S_RUN   | divider free-runs; step on every terminal count
module counter_sequencer #(
    parameter int DIV       = 50000000,
    parameter int DB_CYCLES = 500000,
    parameter int DIV_W     = 26,
    parameter int DB_W      = 19
) (
    input  logic CLK_50,
    input  logic nCLR,
    input  logic btn_run,
    input  logic btn_step,
    input  logic btn_dir,
    output logic step,
    output logic dir,
    output logic running
);

    typedef enum logic {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // Bit 0 = run, bit 1 = step, bit 2 = dir throughout.
    logic [2:0]            raw;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            db_q;
    logic [2:0]            db_d;
    logic [2:0]            press_q;
    logic [2:0]            press_d;
    logic [2:0][DB_W-1:0]  db_cnt_q;
    logic [2:0][DB_W-1:0]  db_cnt_d;

    state_t                state_q;
    state_t                state_d;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic                  step_q;
    logic                  step_d;
    logic                  dir_q;
    logic                  dir_d;

    assign raw = {btn_dir, btn_step, btn_run};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        press_d  = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            press_d[i] = db_d[i] & ~db_q[i];
        end
    end

    // Debounced levels, their counters and the registered press pulses.
    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            db_q     <= '0;
            db_cnt_q <= '0;
            press_q  <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    // Next state, divider and output strobes; a run press always takes
    // priority over a step press or a terminal count in the same cycle.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        step_d  = 1'b0;
        dir_d   = dir_q ^ press_q[2];
        case (state_q)
            S_PAUSE: begin
                if (press_q[0]) begin
                    state_d = S_RUN;
                end else if (press_q[1]) begin
                    step_d = 1'b1;
                end
            end
            S_RUN: begin
                if (press_q[0]) begin
                    state_d = S_PAUSE;
                end else if (div_q == DIV_LAST) begin
                    step_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_PAUSE;
        endcase
    end

    // FSM state, divider and registered outputs.
    always_ff @(posedge CLK_50 or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= S_PAUSE;
            div_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign step    = step_q;
    assign dir     = dir_q;
    assign running = (state_q == S_RUN);

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control block for the 4-bit up/down seconds counter. It debounces three push-buttons: run/pause, single-step and direction. It generates the counter's tick enable from `CLK_50` and presents a single-cycle `step` strobe plus a `dir` level to the counter datapath. The block replaces the free-running divider clock: the counter runs on `CLK_50` and advances only on `step`.

## Interface
Parameters:
- `DIV`, default 50000000: `CLK_50` cycles per tick while running; must be ≥ 2.
- `DB_CYCLES`, default 500000: consecutive stable synchronized cycles required to accept a button level change; must be ≥ 1.
- `DIV_W`, default 26: width of the tick divider counter; must satisfy 2^DIV_W ≥ DIV.
- `DB_W`, default 19: width of each debounce counter; must satisfy 2^DB_W ≥ DB_CYCLES.

Ports:
- `CLK_50`, input, 1: system clock; all logic is on its rising edge.
- `nCLR`, input, 1: reset, asynchronous, active-low.
- `btn_run`, input, 1: raw run/pause button, active-high, asynchronous to `CLK_50`.
- `btn_step`, input, 1: raw single-step button, active-high, asynchronous.
- `btn_dir`, input, 1: raw direction-toggle button, active-high, asynchronous.
- `step`, output, 1: one-cycle strobe; the counter advances by one in the direction given by `dir`.
- `dir`, output, 1: 0 = count up (15 wraps to 0), 1 = count down (0 wraps to 15).
- `running`, output, 1: 1 while the FSM is in RUN.

## Operation
Button conditioning (identical per button):
- Two-flop synchronizer, reset to 0.
- Debounced level `db` resets to 0. A counter increments while the synchronized level ≠ `db`. The counter clears as soon as the synchronized level equals `db`.
- When the counter reaches DB_CYCLES − 1 and the levels still differ, `db` takes the synchronized value and the counter clears.
- `press` is a one-cycle pulse on each 0→1 transition of `db`. Releases produce no pulse.

FSM, 2 states, reset state PAUSE:
- In PAUSE, `press_run` moves the FSM to RUN and clears the divider to 0.
- In PAUSE, `press_step` causes `step` = 1 in the following cycle, and the FSM stays in PAUSE.
- In RUN, `press_run` moves the FSM to PAUSE and clears the divider to 0. If `press_run` coincides with a terminal count, no `step` is issued.
- In RUN, `press_step` is ignored.
- If `press_run` and `press_step` occur in the same cycle in PAUSE, the run press wins: the FSM moves to RUN and no step is issued.

Divider:
- Counts 0..DIV−1 only in RUN and holds at 0 in PAUSE.
- Terminal count (value DIV−1) wraps the divider to 0 and causes `step` = 1 in the next cycle.
- The first step after entering RUN arrives exactly DIV cycles after the FSM transition.

Direction:
- `press_dir` toggles `dir` in the next cycle, in either state.
- If `dir` toggles in the same cycle that `step` is asserted, that step uses the pre-toggle `dir`. `dir` is registered, so the counter samples the old value on that edge.

Reset:
- `nCLR` low forces, asynchronously, `step` = 0, `dir` = 0, `running` = 0 and FSM = PAUSE.
- It also clears all synchronizers, debounce counters, `db` levels and the divider.
- A button held high through reset release produces a press only after a full debounce, DB_CYCLES + 2 cycles after release.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Raw button rising edge (held stable) to `press`: DB_CYCLES + 2 cycles. `press` to `step`/`dir` change: 1 cycle.
- A glitch or bounce shorter than DB_CYCLES synchronized cycles produces no press.
- In steady RUN, `step` pulses exactly every DIV cycles, high for 1 cycle each.
- `step` never remains high for 2 consecutive cycles.
- `running` changes in the same cycle the FSM state changes.

## Test plan
Use DIV = 10, DB_CYCLES = 4 on the bench.
- **Reset:** pulse `nCLR` low mid-RUN. Expect `step` = 0, `dir` = 0 and `running` = 0 immediately. After release, expect no `step` for 100 cycles.
- **Run cadence:** press `btn_run` for 20 cycles. Expect `running` = 1. Expect the first `step` 10 cycles after `running` rises, then every 10 cycles. A model counter must read 1, 2, … 15, 0 (wrap).
- **Debounce:** toggle `btn_step` in PAUSE with 3-cycle bounces before a stable high. Expect exactly one `step`, 7 cycles after the stable high began. A 3-cycle isolated pulse must produce no `step`.
- **Direction:** while running, press `btn_dir`. Expect `dir` = 1 and the model counter to step down. From 0, the next value is 15.
- **Coincidence:** align the `dir` toggle with a `step` cycle. The step must use the old direction. Assert `btn_run` and `btn_step` together in PAUSE: expect RUN and no immediate `step`.
- **Ignored input:** press `btn_step` in RUN. Expect the `step` cadence unchanged, with no extra pulse.
